// File: rtl/bus_arbiter_request_buffer_pkg.sv
// Shared types for the arbiter request buffer:
// lane FSM states, default sizes and next-state helper.
package bus_arbiter_request_buffer_pkg;

    localparam int DEF_NUM_REQUESTS = 2;
    localparam int DEF_BUS_WIDTH    = 8;
    localparam int DEF_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } arb_lane_state_t;

    // Lane FSM step; a disabled lane freezes in place.
    function automatic arb_lane_state_t lane_next(
        arb_lane_state_t cur,
        logic            en,
        logic            has_data,
        logic            popped
    );
        lane_next = cur;
        if (en) begin
            unique case (cur)
                IDLE:    if (has_data) lane_next = REQ;
                REQ:     if (popped) lane_next = HOLD;
                HOLD:    lane_next = has_data ? REQ : IDLE;
                default: lane_next = IDLE;
            endcase
        end
    endfunction

endpackage

// File: rtl/bus_arbiter_request_buffer_if.sv
// Producer/arbiter-facing bundle of the request buffer.
// The buffer uses the slave modport.
interface bus_arbiter_request_buffer_if
    import bus_arbiter_request_buffer_pkg::*;
#(
    parameter int NUM_REQUESTS = DEF_NUM_REQUESTS,
    parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
    parameter int CNT_WIDTH    = $clog2(DEF_FIFO_DEPTH) + 1
);
    logic [NUM_REQUESTS-1:0]                in_valid;
    logic [NUM_REQUESTS-1:0][BUS_WIDTH-1:0] in_data;
    logic [NUM_REQUESTS-1:0]                in_ready;
    logic [NUM_REQUESTS-1:0]                req;
    logic [NUM_REQUESTS-1:0]                grant;
    logic [NUM_REQUESTS-1:0][BUS_WIDTH-1:0] bus_in;
    logic [NUM_REQUESTS-1:0][CNT_WIDTH-1:0] lane_count;
    logic                                   grant_err;

    modport master (
        output in_valid, in_data, grant,
        input  in_ready, req, bus_in, lane_count, grant_err
    );

    modport slave (
        input  in_valid, in_data, grant,
        output in_ready, req, bus_in, lane_count, grant_err
    );

endinterface

// File: rtl/bus_arbiter_request_buffer_lane_fifo.sv
// Per-lane FIFO: counter-based full/empty,
// wrapping pointers, head forced to 0 when empty.
module bus_arbiter_lane_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bus_arbiter_request_buffer.sv
// Lane FIFOs feeding the bus arbiter: per-lane req FSM,
// grant legality check and sticky grant error flag.
module bus_arbiter_request_buffer
    import bus_arbiter_request_buffer_pkg::*;
#(
    parameter int NUM_REQUESTS = DEF_NUM_REQUESTS,
    parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input logic ap_clk,
    input logic ap_rst_n,
    input logic enable,
    bus_arbiter_request_buffer_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

    arb_lane_state_t state_q [NUM_REQUESTS];
    arb_lane_state_t state_d [NUM_REQUESTS];

    logic [NUM_REQUESTS-1:0]                full;
    logic [NUM_REQUESTS-1:0]                empty;
    logic [NUM_REQUESTS-1:0]                push;
    logic [NUM_REQUESTS-1:0]                pop;
    logic [NUM_REQUESTS-1:0]                in_req;
    logic [NUM_REQUESTS-1:0][BUS_WIDTH-1:0] head;
    logic [NUM_REQUESTS-1:0][CNT_WIDTH-1:0] count;
    logic                                   grant_legal;
    logic                                   grant_bad;
    logic                                   grant_err_q;

    for (genvar i = 0; i < NUM_REQUESTS; i++) begin : g_lane
        assign in_req[i] = (state_q[i] == REQ);

        bus_arbiter_lane_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (BUS_WIDTH),
            .CW    (CNT_WIDTH)
        ) u_fifo (
            .clk   (ap_clk),
            .rst_n (ap_rst_n),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata (bus.in_data[i]),
            .head  (head[i]),
            .count (count[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    assign push           = bus.in_valid & ~full;
    assign bus.in_ready   = ~full;
    assign bus.req        = in_req & {NUM_REQUESTS{enable}};
    assign bus.bus_in     = head;
    assign bus.lane_count = count;
    assign bus.grant_err  = grant_err_q;

    // A grant is honoured only when one-hot, enabled and aimed at a REQ lane.
    always_comb begin
        grant_legal = enable
                   && $onehot0(bus.grant)
                   && ((bus.grant & ~in_req) == '0);
        grant_bad   = (|bus.grant) && !grant_legal;
        pop         = grant_legal ? bus.grant : '0;
    end

    // Lane next-state: data presence counts a push landing this edge.
    always_comb begin
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            state_d[i] = lane_next(state_q[i], enable,
                                   !empty[i] || push[i], pop[i]);
        end
    end

    // Lane state registers.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_REQUESTS; i++) state_q[i] <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky illegal-grant flag, cleared only by reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n)      grant_err_q <= 1'b0;
        else if (grant_bad) grant_err_q <= 1'b1;
    end

endmodule

// File: tb/tb_bus_arbiter_request_buffer.sv
// Scoreboard bench: queue-based lane model predicts outputs
// after every edge; a monitor compares them 1ns later.
module tb_bus_arbiter_request_buffer;

    localparam int NR    = 2;
    localparam int BW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [NR-1:0]         rdy;
        logic [NR-1:0]         req;
        logic [NR-1:0][BW-1:0] bus;
        logic [NR-1:0][CW-1:0] cnt;
        logic                  err;
    } snap_t;

    logic ap_clk;
    logic ap_rst_n;
    logic enable;

    bus_arbiter_request_buffer_if #(
        .NUM_REQUESTS (NR),
        .BUS_WIDTH    (BW),
        .CNT_WIDTH    (CW)
    ) bus_if ();

    bus_arbiter_request_buffer #(
        .NUM_REQUESTS (NR),
        .BUS_WIDTH    (BW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .enable   (enable),
        .bus      (bus_if)
    );

    int total = 0;
    int bad   = 0;

    snap_t       exp_q [$];
    logic [BW-1:0] mq [NR][$];
    bit          armed [NR];
    bit          cool  [NR];
    bit          merr;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Reference model: lane queues, presenting/cooldown flags, sticky error.
    always @(posedge ap_clk) begin
        snap_t s;
        bit    legal;
        bit    popl;
        bit    acc;
        if (!ap_rst_n) begin
            for (int i = 0; i < NR; i++) begin
                mq[i].delete();
                armed[i] = 0;
                cool[i]  = 0;
            end
            merr = 0;
        end else begin
            legal = enable && ($countones(bus_if.grant) <= 1);
            for (int i = 0; i < NR; i++)
                if (bus_if.grant[i] && !armed[i]) legal = 0;
            if (bus_if.grant != 0 && !legal) merr = 1;
            for (int i = 0; i < NR; i++) begin
                acc  = bus_if.in_valid[i] && (mq[i].size() < DEPTH);
                popl = legal && bus_if.grant[i];
                if (popl) void'(mq[i].pop_front());
                if (acc) mq[i].push_back(bus_if.in_data[i]);
                if (enable) begin
                    if (cool[i]) begin
                        cool[i]  = 0;
                        armed[i] = mq[i].size() > 0;
                    end else if (armed[i]) begin
                        if (popl) begin
                            armed[i] = 0;
                            cool[i]  = 1;
                        end
                    end else begin
                        armed[i] = mq[i].size() > 0;
                    end
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            s.rdy[i] = mq[i].size() < DEPTH;
            s.req[i] = armed[i] && enable;
            s.bus[i] = (mq[i].size() > 0) ? mq[i][0] : '0;
            s.cnt[i] = CW'(mq[i].size());
        end
        s.err = merr;
        exp_q.push_back(s);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: pop one expectation per edge and compare all outputs.
    always @(posedge ap_clk) begin
        snap_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("in_ready", 32'(bus_if.in_ready), 32'(e.rdy));
            chk("req", 32'(bus_if.req), 32'(e.req));
            chk("grant_err", 32'(bus_if.grant_err), 32'(e.err));
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("bus_in[%0d]", i),
                    32'(bus_if.bus_in[i]), 32'(e.bus[i]));
                chk($sformatf("lane_count[%0d]", i),
                    32'(bus_if.lane_count[i]), 32'(e.cnt[i]));
            end
        end
    end

    task automatic cyc(logic [1:0] v, logic [7:0] d0,
                       logic [7:0] d1, logic [1:0] g);
        bus_if.in_valid   = v;
        bus_if.in_data[0] = d0;
        bus_if.in_data[1] = d1;
        bus_if.grant      = g;
        @(posedge ap_clk);
        #2;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cyc(2'b00, 8'h00, 8'h00, 2'b00);
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        idle(1);
        ap_rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] v;
        logic [1:0] g;
        ap_rst_n = 1'b0;
        enable   = 1'b1;
        idle(2);
        ap_rst_n = 1'b1;

        cyc(2'b01, 8'hA5, 8'h00, 2'b00);
        idle(1);
        cyc(2'b00, 8'h00, 8'h00, 2'b01);
        idle(2);

        for (int k = 0; k < 5; k++)
            cyc(2'b10, 8'h00, 8'(8'h30 + k), 2'b00);
        idle(1);

        cyc(2'b01, 8'h11, 8'h00, 2'b00);
        cyc(2'b01, 8'h22, 8'h00, 2'b00);
        idle(1);
        cyc(2'b00, 8'h00, 8'h00, 2'b01);
        idle(2);

        cyc(2'b00, 8'h00, 8'h00, 2'b11);
        idle(2);
        do_reset();

        cyc(2'b01, 8'h41, 8'h00, 2'b00);
        cyc(2'b01, 8'h42, 8'h00, 2'b00);
        idle(1);
        enable = 1'b0;
        cyc(2'b10, 8'h00, 8'h51, 2'b00);
        cyc(2'b00, 8'h00, 8'h00, 2'b01);
        idle(1);
        enable = 1'b1;
        idle(2);
        do_reset();

        cyc(2'b01, 8'h61, 8'h00, 2'b00);
        cyc(2'b01, 8'h62, 8'h00, 2'b00);
        idle(1);
        cyc(2'b01, 8'h63, 8'h00, 2'b01);
        idle(3);

        for (int n = 0; n < 800; n++) begin
            ap_rst_n = ($urandom_range(0, 149) != 0);
            enable   = ($urandom_range(0, 7) != 0);
            v        = 2'($urandom);
            g        = 2'b00;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    if (armed[0] && armed[1])
                        g = $urandom_range(0, 1) ? 2'b01 : 2'b10;
                    else if (armed[0]) g = 2'b01;
                    else if (armed[1]) g = 2'b10;
                end
                9:       g = 2'($urandom);
                default: g = 2'b00;
            endcase
            cyc(v, 8'($urandom), 8'($urandom), g);
        end

        ap_rst_n = 1'b1;
        enable   = 1'b1;
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
